nw_cell_sequencer: RTL and testbench
====================================

// Module: nw_cell_sequencer
// PURPOSE
//  Drives the Needleman-Wunsch fill: initialises score/direction RAM borders, then walks interior cells (i,j) row-major.
//  Per cell: reads diag/up/lx from score RAM, presents them with the match flag to the Max cell, writes back max/symbol.
//  Sits between the score/direction RAMs and the Max cell; owns the handshake via the 255 "not valid" sentinel.
// PARAMETERS
//  N          8     sequence length (2..60); matrix is (N+1)x(N+1)
//  ADDR_W     7     RAM address width, >= clog2((N+1)*(N+1))
//  GAP_SCORE  -2    border increment per step
//  ARROW_LX   3'b100 / ARROW_UP 3'b010   border direction codes
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-low reset
//  start        in   1       begin fill; sampled only in IDLE
//  seq_a        in   2*N     row sequence, 2-bit symbols, char k at [2k+1:2k]
//  seq_b        in   2*N     column sequence, same packing
//  ram_addr     out  ADDR_W  score RAM address = i*(N+1)+j
//  ram_we       out  1       score RAM write enable
//  ram_wdata    out  9       signed score to write
//  ram_rdata    in   9       signed score read, 1-cycle read latency
//  dir_we       out  1       direction RAM write enable (same address as ram_addr)
//  dir_wdata    out  3       direction symbol to write
//  value        out  1       1 = seq_a[i-1]==seq_b[j-1]
//  diag/up/lx   out  9 each  signed operands to Max; 255 when not presenting
//  max_in       in   9       Max result
//  symbol_in    in   3       Max direction symbol
//  calculated   in   1       Max valid flag
//  busy         out  1       high from INIT through DONE
//  done         out  1       one-cycle pulse at completion
//  final_score  out  9       score of cell (N,N), held until next start
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE; ram_we=dir_we=0, ram_addr=0, wdata=0, value=0, diag=up=lx=255, busy=done=0, final_score=0.
//  Reset mid-fill aborts immediately; no further writes; RAM contents undefined.
//  States: IDLE -> INIT -> RD_D -> RD_U -> RD_L -> LAT -> EVAL -> WR -> (RD_D next cell | DONE) -> IDLE.
//  IDLE: start=1 latches seq_a/seq_b, enters INIT; start ignored in all other states.
//  INIT: 2N+1 cycles, one write/cycle with ram_we=dir_we=1:
//    (0,0)=0/3'b000; (0,j)=j*GAP/ARROW_LX for j=1..N; (i,0)=i*GAP/ARROW_UP for i=1..N. Then i=j=1.
//  RD_D addr (i-1,j-1); RD_U addr (i-1,j), capture diag; RD_L addr (i,j-1), capture up; LAT capture lx.
//  EVAL: drive diag/up/lx registers and value; stay while calculated=0 (no timeout); nominal 2 cycles.
//  WR: ram_we=dir_we=1 at (i,j), data = max_in/symbol_in; diag/up/lx return to 255 so Max drops calculated.
//  Outside EVAL, diag/up/lx=255 always; guarantees stale calculated never accepted for a new cell.
//  Cell advance: j++; j==N -> j=1, i++; after WR of (N,N): final_score<=max_in, go DONE.
//  DONE: done=1 for one cycle, busy=1; then IDLE, busy=0.
//  Nominal latency start->done pulse: 1 + (2N+1) + 7*N*N cycles (N=4: 122).
//  Arithmetic: 9-bit signed, border i*GAP computed by accumulation; N<=60 guarantees no overflow and no 255 result.
// TESTING
//  1 rst=0 with start=1 for 3 cycles -> all outputs at reset values, no RAM writes, busy=0.
//  2 N=4 start -> INIT writes 9 cells: row0 0,-2,-4,-6,-8 dirs 000,100x4; col0 -2,-4,-6,-8 dirs 010.
//  3 N=4 seq_a=seq_b=AAAA, behavioural Max -> diagonal cells 1,2,3,4 dir 001; final_score=4; done once, 122 cycles.
//  4 N=4 AAAA vs CCCC -> final_score=-4, (N,N) dir 001; no write with data 255 ever.
//  5 Max model delays calculated 5 extra cycles at (2,2) -> stays in EVAL, operands stable, single write after.
//  6 rst=0 during EVAL of (2,3), then restart same data -> no writes during reset, results match test 3.

Source files
------------

// File: rtl/nw_cell_sequencer.sv
// Needleman-Wunsch fill sequencer: writes the score/direction borders, then walks
// interior cells row-major, feeding the Max cell and writing back its result.
module nw_cell_sequencer #(
    parameter int          N         = 8,
    parameter int unsigned ADDR_W    = 7,
    parameter int          GAP_SCORE = -2,
    parameter logic [2:0]  ARROW_LX  = 3'b100,
    parameter logic [2:0]  ARROW_UP  = 3'b010
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*N-1:0]      seq_a,
    input  logic [2*N-1:0]      seq_b,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic signed [8:0]   ram_wdata,
    input  logic signed [8:0]   ram_rdata,
    output logic                dir_we,
    output logic [2:0]          dir_wdata,
    output logic                value,
    output logic signed [8:0]   diag,
    output logic signed [8:0]   up,
    output logic signed [8:0]   lx,
    input  logic signed [8:0]   max_in,
    input  logic [2:0]          symbol_in,
    input  logic                calculated,
    output logic                busy,
    output logic                done,
    output logic signed [8:0]   final_score
);

    localparam int unsigned     IDX_W = $clog2(N + 2);
    localparam int              ROW   = N + 1;
    localparam logic signed [8:0] GAP = 9'(GAP_SCORE);
    localparam logic signed [8:0] NV  = 9'sd255;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_RD_D, S_RD_U, S_RD_L, S_LAT, S_EVAL, S_WR, S_DONE
    } state_t;

    state_t state, state_d;
    logic [IDX_W-1:0]     i, i_d, j, j_d;
    logic signed [8:0]    acc, acc_d, diag_q, diag_q_d, up_q, up_q_d;
    logic [2*N-1:0]       sa, sa_d, sb, sb_d, sa_sh, sb_sh;
    logic [ADDR_W-1:0]    addr_d;
    logic                 we_d, value_d, busy_d, done_d;
    logic signed [8:0]    wdata_d, diag_d, up_d, lx_d, final_d;
    logic [2:0]           dir_d;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] c);
        return ADDR_W'(int'(r) * ROW + int'(c));
    endfunction

    // Symbols of the current cell: seq_a[i-1] and seq_b[j-1]
    assign sa_sh = sa >> {i - ONE, 1'b0};
    assign sb_sh = sb >> {j - ONE, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            i           <= '0;
            j           <= '0;
            acc         <= '0;
            sa          <= '0;
            sb          <= '0;
            diag_q      <= '0;
            up_q        <= '0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            dir_we      <= 1'b0;
            dir_wdata   <= '0;
            value       <= 1'b0;
            diag        <= NV;
            up          <= NV;
            lx          <= NV;
            busy        <= 1'b0;
            done        <= 1'b0;
            final_score <= '0;
        end else begin
            state       <= state_d;
            i           <= i_d;
            j           <= j_d;
            acc         <= acc_d;
            sa          <= sa_d;
            sb          <= sb_d;
            diag_q      <= diag_q_d;
            up_q        <= up_q_d;
            ram_addr    <= addr_d;
            ram_we      <= we_d;
            ram_wdata   <= wdata_d;
            dir_we      <= we_d;
            dir_wdata   <= dir_d;
            value       <= value_d;
            diag        <= diag_d;
            up          <= up_d;
            lx          <= lx_d;
            busy        <= busy_d;
            done        <= done_d;
            final_score <= final_d;
        end
    end

    // Next state plus next values of every registered output; i==j==0 in INIT marks borders complete
    always_comb begin
        state_d  = state;
        i_d      = i;
        j_d      = j;
        acc_d    = acc;
        sa_d     = sa;
        sb_d     = sb;
        diag_q_d = diag_q;
        up_q_d   = up_q;
        addr_d   = ram_addr;
        we_d     = 1'b0;
        wdata_d  = ram_wdata;
        dir_d    = dir_wdata;
        value_d  = 1'b0;
        diag_d   = NV;
        up_d     = NV;
        lx_d     = NV;
        busy_d   = busy;
        done_d   = 1'b0;
        final_d  = final_score;
        case (state)
            S_IDLE: begin
                if (start) begin
                    sa_d    = seq_a;
                    sb_d    = seq_b;
                    state_d = S_INIT;
                    busy_d  = 1'b1;
                    i_d     = '0;
                    j_d     = ONE;
                    acc_d   = GAP;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    wdata_d = '0;
                    dir_d   = 3'b000;
                end
            end
            S_INIT: begin
                if (j != '0) begin
                    we_d    = 1'b1;
                    addr_d  = addr_of('0, j);
                    wdata_d = acc;
                    dir_d   = ARROW_LX;
                    if (j == LAST) begin
                        i_d   = ONE;
                        j_d   = '0;
                        acc_d = GAP;
                    end else begin
                        j_d   = j + ONE;
                        acc_d = acc + GAP;
                    end
                end else if (i != '0) begin
                    we_d    = 1'b1;
                    addr_d  = addr_of(i, '0);
                    wdata_d = acc;
                    dir_d   = ARROW_UP;
                    if (i == LAST) begin
                        i_d = '0;
                    end else begin
                        i_d   = i + ONE;
                        acc_d = acc + GAP;
                    end
                end else begin
                    state_d = S_RD_D;
                    i_d     = ONE;
                    j_d     = ONE;
                    addr_d  = '0;
                end
            end
            S_RD_D: begin
                state_d = S_RD_U;
                addr_d  = addr_of(i - ONE, j);
            end
            S_RD_U: begin
                state_d  = S_RD_L;
                diag_q_d = ram_rdata;
                addr_d   = addr_of(i, j - ONE);
            end
            S_RD_L: begin
                state_d = S_LAT;
                up_q_d  = ram_rdata;
            end
            S_LAT: begin
                state_d = S_EVAL;
                diag_d  = diag_q;
                up_d    = up_q;
                lx_d    = ram_rdata;
                value_d = (sa_sh[1:0] == sb_sh[1:0]);
            end
            S_EVAL: begin
                value_d = value;
                diag_d  = diag;
                up_d    = up;
                lx_d    = lx;
                if (calculated) begin
                    state_d = S_WR;
                    value_d = 1'b0;
                    diag_d  = NV;
                    up_d    = NV;
                    lx_d    = NV;
                    we_d    = 1'b1;
                    addr_d  = addr_of(i, j);
                    wdata_d = max_in;
                    dir_d   = symbol_in;
                    if (i == LAST && j == LAST) final_d = max_in;
                end
            end
            S_WR: begin
                if (i == LAST && j == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RD_D;
                    if (j == LAST) begin
                        i_d    = i + ONE;
                        j_d    = ONE;
                        addr_d = addr_of(i, '0);
                    end else begin
                        j_d    = j + ONE;
                        addr_d = addr_of(i - ONE, j);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nw_cell_sequencer.sv
// Bench for nw_cell_sequencer: RAM and Max behavioural models plus a write scoreboard
// filled from an independent Needleman-Wunsch reference.
module tb_nw_cell_sequencer;

    localparam int N      = 4;
    localparam int ADDR_W = 7;
    localparam logic signed [8:0] NV = 9'sd255;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic signed [8:0] data;
        logic [2:0]        dir;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [2*N-1:0]      seq_a = '0, seq_b = '0;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we, dir_we, value, busy, done;
    logic signed [8:0]   ram_wdata, diag, up, lx, final_score;
    logic signed [8:0]   ram_rdata = '0;
    logic signed [8:0]   max_in = '0;
    logic [2:0]          dir_wdata;
    logic [2:0]          symbol_in = '0;
    logic                calculated = 1'b0;

    logic signed [8:0]   smem [0:(1<<ADDR_W)-1];
    logic [2:0]          dmem [0:(1<<ADDR_W)-1];

    exp_t exp_q[$];
    int n_vec = 0, n_fail = 0;
    int wr_count = 0, done_count = 0, rst_writes = 0;
    int delay_at = -1, extra_delay = 0, hold_cnt = 0;
    int exp_final = 0;
    int d_s, u_s, l_s;
    logic signed [8:0] pdiag = NV, pup = NV, plx = NV;
    logic pval = 1'b0;

    nw_cell_sequencer #(.N(N), .ADDR_W(ADDR_W), .GAP_SCORE(-2)) dut (
        .clk(clk), .rst(rst), .start(start), .seq_a(seq_a), .seq_b(seq_b),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dir_we(dir_we), .dir_wdata(dir_wdata), .value(value),
        .diag(diag), .up(up), .lx(lx),
        .max_in(max_in), .symbol_in(symbol_in), .calculated(calculated),
        .busy(busy), .done(done), .final_score(final_score)
    );

    always #5 clk = ~clk;

    // Synchronous RAMs with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we === 1'b1) smem[ram_addr] <= ram_wdata;
        if (dir_we === 1'b1) dmem[ram_addr] <= dir_wdata;
        ram_rdata <= smem[ram_addr];
    end

    // Behavioural Max cell: match +1, mismatch -1, gap -2, tie priority diag > up > left
    always_comb begin
        d_s = int'(diag) + (value ? 1 : -1);
        u_s = int'(up) - 2;
        l_s = int'(lx) - 2;
    end

    always @(posedge clk) begin
        if (!rst || diag == NV || up == NV || lx == NV) begin
            calculated <= 1'b0;
            hold_cnt   <= 0;
        end else begin
            hold_cnt <= hold_cnt + 1;
            if (hold_cnt >= ((wr_count == delay_at) ? extra_delay : 0)) begin
                calculated <= 1'b1;
                if (d_s >= u_s && d_s >= l_s) begin
                    max_in <= 9'(d_s); symbol_in <= 3'b001;
                end else if (u_s >= l_s) begin
                    max_in <= 9'(u_s); symbol_in <= 3'b010;
                end else begin
                    max_in <= 9'(l_s); symbol_in <= 3'b100;
                end
            end
        end
    end

    // Scoreboard and operand-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && (ram_we === 1'b1 || dir_we === 1'b1)) rst_writes++;
        if (rst && done === 1'b1) done_count++;
        if (rst && (ram_we === 1'b1 || dir_we === 1'b1)) begin
            exp_t e;
            wr_count++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%0d data=%0d dir=%b", ram_addr, ram_wdata, dir_wdata);
            end else begin
                e = exp_q.pop_front();
                if (ram_addr !== e.addr || ram_wdata !== e.data || dir_wdata !== e.dir
                    || ram_we !== 1'b1 || dir_we !== 1'b1 || ram_wdata === NV) begin
                    n_fail++;
                    $display("FAIL write got addr=%0d data=%0d dir=%b we=%b/%b expected addr=%0d data=%0d dir=%b",
                             ram_addr, ram_wdata, dir_wdata, ram_we, dir_we, e.addr, e.data, e.dir);
                end
            end
        end
        if (rst && diag !== NV && pdiag !== NV) begin
            n_vec++;
            if (diag !== pdiag || up !== pup || lx !== plx || value !== pval) begin
                n_fail++;
                $display("FAIL operand_stable got %0d/%0d/%0d v%b expected %0d/%0d/%0d v%b",
                         diag, up, lx, value, pdiag, pup, plx, pval);
            end
        end
        pdiag = diag; pup = up; plx = lx; pval = value;
    end

    // Reference fill: pushes every expected write in the order the sequencer must issue them
    task automatic push_expected(input logic [2*N-1:0] a, input logic [2*N-1:0] b);
        int sc [0:N][0:N];
        logic [2:0] dr;
        int s, d, u, l;
        sc[0][0] = 0;
        exp_q.push_back('{addr: '0, data: '0, dir: 3'b000});
        for (int jj = 1; jj <= N; jj++) begin
            sc[0][jj] = -2 * jj;
            exp_q.push_back('{addr: ADDR_W'(jj), data: 9'(sc[0][jj]), dir: 3'b100});
        end
        for (int ii = 1; ii <= N; ii++) begin
            sc[ii][0] = -2 * ii;
            exp_q.push_back('{addr: ADDR_W'(ii * (N + 1)), data: 9'(sc[ii][0]), dir: 3'b010});
        end
        for (int ii = 1; ii <= N; ii++) begin
            for (int jj = 1; jj <= N; jj++) begin
                s = (a[2*(ii-1) +: 2] == b[2*(jj-1) +: 2]) ? 1 : -1;
                d = sc[ii-1][jj-1] + s;
                u = sc[ii-1][jj] - 2;
                l = sc[ii][jj-1] - 2;
                if (d >= u && d >= l) begin sc[ii][jj] = d; dr = 3'b001; end
                else if (u >= l)      begin sc[ii][jj] = u; dr = 3'b010; end
                else                  begin sc[ii][jj] = l; dr = 3'b100; end
                exp_q.push_back('{addr: ADDR_W'(ii * (N + 1) + jj), data: 9'(sc[ii][jj]), dir: dr});
            end
        end
        exp_final = sc[N][N];
    endtask

    // Starts a fill and waits for done; scrambles the inputs after start to prove they were latched
    task automatic run_fill(input logic [2*N-1:0] a, input logic [2*N-1:0] b,
                            output int cycles, output logic busy_early);
        push_expected(a, b);
        @(negedge clk);
        seq_a = a; seq_b = b; start = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1;
        start = 1'b0; seq_a = ~a; seq_b = ~b;
        busy_early = busy;
        while (done !== 1'b1 && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (done !== 1'b1) begin
            n_vec++; n_fail++;
            $display("FAIL fill_timeout got no done after %0d cycles", cycles);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; seq_a = 8'h1b; seq_b = 8'he4;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ram_we !== 1'b0 || dir_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b/%b expected 0/0", ram_we, dir_we); end
        n_vec++; if (ram_addr !== '0 || ram_wdata !== '0) begin n_fail++; $display("FAIL rst_addr_data got %0d/%0d expected 0/0", ram_addr, ram_wdata); end
        n_vec++; if (diag !== NV || up !== NV || lx !== NV || value !== 1'b0) begin n_fail++; $display("FAIL rst_operands got %0d/%0d/%0d v%b expected 255/255/255 v0", diag, up, lx, value); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_busy_done got %b/%b expected 0/0", busy, done); end
        n_vec++; if (final_score !== '0) begin n_fail++; $display("FAIL rst_final got %0d expected 0", final_score); end
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0 || wr_count !== 0 || rst_writes !== 0) begin n_fail++; $display("FAIL rst_idle got busy=%b writes=%0d/%0d expected 0/0/0", busy, wr_count, rst_writes); end
    endtask

    task automatic test_init();
        int cyc, d0;
        logic be;
        d0 = done_count;
        run_fill(8'he4, 8'h1b, cyc, be);
        n_vec++; if (smem[0] !== 9'sd0 || dmem[0] !== 3'b000) begin n_fail++; $display("FAIL init_origin got %0d/%b expected 0/000", smem[0], dmem[0]); end
        for (int k = 1; k <= N; k++) begin
            n_vec++;
            if (smem[k] !== 9'(-2 * k) || dmem[k] !== 3'b100) begin
                n_fail++; $display("FAIL init_row0_%0d got %0d/%b expected %0d/100", k, smem[k], dmem[k], -2 * k);
            end
            n_vec++;
            if (smem[k * (N + 1)] !== 9'(-2 * k) || dmem[k * (N + 1)] !== 3'b010) begin
                n_fail++; $display("FAIL init_col0_%0d got %0d/%b expected %0d/010", k, smem[k * (N + 1)], dmem[k * (N + 1)], -2 * k);
            end
        end
        n_vec++; if (final_score !== 9'(exp_final)) begin n_fail++; $display("FAIL init_final got %0d expected %0d", final_score, exp_final); end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL init_pending got %0d expected 0", exp_q.size()); end
        n_vec++; if (done_count - d0 != 1) begin n_fail++; $display("FAIL init_done_count got %0d expected 1", done_count - d0); end
    endtask

    task automatic test_match();
        int cyc, d0;
        logic be;
        d0 = done_count;
        run_fill(8'h00, 8'h00, cyc, be);
        n_vec++; if (be !== 1'b1) begin n_fail++; $display("FAIL match_busy got %b expected 1", be); end
        n_vec++; if (cyc != 122) begin n_fail++; $display("FAIL match_latency got %0d expected 122", cyc); end
        n_vec++; if (final_score !== 9'sd4) begin n_fail++; $display("FAIL match_final got %0d expected 4", final_score); end
        for (int k = 1; k <= N; k++) begin
            n_vec++;
            if (smem[k * (N + 2)] !== 9'(k) || dmem[k * (N + 2)] !== 3'b001) begin
                n_fail++; $display("FAIL match_diag_%0d got %0d/%b expected %0d/001", k, smem[k * (N + 2)], dmem[k * (N + 2)], k);
            end
        end
        n_vec++; if (done_count - d0 != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL match_done got %0d busy=%b expected 1 busy=0", done_count - d0, busy); end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL match_pending got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_mismatch();
        int cyc;
        logic be;
        run_fill(8'h00, 8'h55, cyc, be);
        n_vec++; if (final_score !== -9'sd4) begin n_fail++; $display("FAIL mism_final got %0d expected -4", final_score); end
        n_vec++; if (dmem[N * (N + 2)] !== 3'b001) begin n_fail++; $display("FAIL mism_dir got %b expected 001", dmem[N * (N + 2)]); end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mism_pending got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_slow_max();
        int cyc;
        logic be;
        delay_at = wr_count + (2 * N + 1) + N + 1;
        extra_delay = 5;
        run_fill(8'h00, 8'h00, cyc, be);
        extra_delay = 0;
        delay_at = -1;
        n_vec++; if (cyc != 127) begin n_fail++; $display("FAIL slow_latency got %0d expected 127", cyc); end
        n_vec++; if (final_score !== 9'sd4) begin n_fail++; $display("FAIL slow_final got %0d expected 4", final_score); end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL slow_pending got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_fill();
        int base, guard, cyc, r0;
        logic be;
        base = wr_count;
        r0 = rst_writes;
        push_expected(8'h00, 8'h00);
        @(negedge clk);
        seq_a = 8'h00; seq_b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!(wr_count - base == (2 * N + 1) + N + 2 && diag !== NV) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        n_vec++; if (guard >= 3000) begin n_fail++; $display("FAIL abort_reach_eval got timeout expected EVAL of (2,3)"); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0 || ram_we !== 1'b0 || diag !== NV || lx !== NV) begin n_fail++; $display("FAIL abort_outputs got busy=%b we=%b diag=%0d lx=%0d expected 0/0/255/255", busy, ram_we, diag, lx); end
        @(negedge clk);
        n_vec++; if (rst_writes != r0) begin n_fail++; $display("FAIL abort_writes got %0d expected 0", rst_writes - r0); end
        exp_q.delete();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        run_fill(8'h00, 8'h00, cyc, be);
        n_vec++; if (cyc != 122 || final_score !== 9'sd4) begin n_fail++; $display("FAIL restart got %0d cyc final=%0d expected 122 cyc final=4", cyc, final_score); end
        n_vec++; if (smem[N + 2] !== 9'sd1 || smem[2 * (N + 2)] !== 9'sd2) begin n_fail++; $display("FAIL restart_diag got %0d/%0d expected 1/2", smem[N + 2], smem[2 * (N + 2)]); end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL restart_pending got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_match();
        test_mismatch();
        test_slow_max();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
